// File: rtl/cop0_intc_pkg.sv
// Shared constants for the cop0 interrupt/timer front end: register map and cause bit positions.
package cop0_intc_pkg;

  typedef enum logic [2:0] {
    INTC_PENDING = 3'd0,
    INTC_EDGE    = 3'd1,
    INTC_ENABLE  = 3'd2,
    INTC_COUNT   = 3'd3,
    INTC_COMPARE = 3'd4,
    INTC_TPEND   = 3'd5
  } intc_addr_e;

  localparam int CAUSE_BASE  = 8;
  localparam int CAUSE_TIMER = 15;

endpackage

// File: rtl/cop0_intc_if.sv
// mfc0/mtc0-style register port with the pipeline's one-cycle read stall.
interface cop0_intc_if;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        stalled;

  modport master (output addr, wdata, we, re, input rdata, stalled);
  modport slave  (input addr, wdata, we, re, output rdata, stalled);
endinterface

// File: rtl/cop0_intc_timer.sv
// Count/Compare timer: free-running COUNT, COMPARE match sets sticky TPEND.
module cop0_intc_timer #(
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            count_we,
  input  logic            compare_we,
  input  logic [CNTW-1:0] wdata,
  output logic [CNTW-1:0] count,
  output logic [CNTW-1:0] compare,
  output logic            tpend,
  output logic            match
);

  // COMPARE of zero disarms the timer so a wrapping COUNT never fires it
  assign match = (count == compare) && (compare != '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count   <= '0;
      compare <= '0;
      tpend   <= 1'b0;
    end else begin
      count <= count_we ? wdata : count + 1'b1;
      if (compare_we) begin
        compare <= wdata;
        tpend   <= 1'b0;
      end else if (match) begin
        tpend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cop0_intc.sv
// Interrupt pending/mask front end producing cop0 ext_cause[15:8].
// Define INTC_TIMER_EN to include the Count/Compare timer (cop0_intc_timer).
module cop0_intc
  import cop0_intc_pkg::*;
#(
  parameter int NUMIRQ = 6,
  parameter int CNTW   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NUMIRQ-1:0] irq_in,
  cop0_intc_if.slave        bus,
  output logic [31:0]       ext_cause
);

  logic [NUMIRQ-1:0] pending, edge_mode, enable, irq_prev, w1c, rise;
  logic [31:0]       rdata_q, rd_val, cause_next;
  logic              t_q, tpend_bit, line6_bit, unused_bits;

  assign bus.stalled = t_q ? 1'b0 : bus.re;
  assign bus.rdata   = rdata_q;

  assign w1c  = (bus.we && bus.addr == INTC_PENDING) ? bus.wdata[NUMIRQ-1:0] : '0;
  assign rise = irq_in & ~irq_prev;

`ifdef INTC_TIMER_EN
  logic [CNTW-1:0] count, compare;
  logic            tpend, timer_match;

  cop0_intc_timer #(.CNTW(CNTW)) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (bus.we && bus.addr == INTC_COUNT),
    .compare_we (bus.we && bus.addr == INTC_COMPARE),
    .wdata      (bus.wdata[CNTW-1:0]),
    .count      (count),
    .compare    (compare),
    .tpend      (tpend),
    .match      (timer_match)
  );

  assign tpend_bit   = tpend;
  assign unused_bits = ^{bus.wdata, timer_match};
`else
  assign tpend_bit   = 1'b0;
  assign unused_bits = ^bus.wdata;
`endif

  // A seventh line also shares the timer cause bit
  if (NUMIRQ == 7) begin : g_line6
    assign line6_bit = pending[NUMIRQ-1] & enable[NUMIRQ-1];
  end else begin : g_no_line6
    assign line6_bit = 1'b0;
  end

  always_comb begin
    cause_next = '0;
    for (int i = 0; i < NUMIRQ; i++) cause_next[CAUSE_BASE+i] = pending[i] & enable[i];
    cause_next[CAUSE_TIMER] = tpend_bit | line6_bit;
  end

  always_comb begin
    rd_val = '0;
    case (bus.addr)
      INTC_PENDING: rd_val[NUMIRQ-1:0] = pending;
      INTC_EDGE:    rd_val[NUMIRQ-1:0] = edge_mode;
      INTC_ENABLE:  rd_val[NUMIRQ-1:0] = enable;
`ifdef INTC_TIMER_EN
      INTC_COUNT:   rd_val[CNTW-1:0]   = count;
      INTC_COMPARE: rd_val[CNTW-1:0]   = compare;
      INTC_TPEND:   rd_val[0]          = tpend;
`endif
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending   <= '0;
      edge_mode <= '0;
      enable    <= '0;
      irq_prev  <= '0;
      ext_cause <= '0;
      rdata_q   <= '0;
      t_q       <= 1'b0;
    end else begin
      irq_prev <= irq_in;
      // Edge lines: new edge beats a same-cycle W1C; level lines track the input
      pending  <= (edge_mode & ((pending & ~w1c) | rise)) | (~edge_mode & irq_in);
      if (bus.we && bus.addr == INTC_EDGE)   edge_mode <= bus.wdata[NUMIRQ-1:0];
      if (bus.we && bus.addr == INTC_ENABLE) enable    <= bus.wdata[NUMIRQ-1:0];
      ext_cause <= cause_next;
      t_q       <= bus.stalled;
      if (bus.stalled) rdata_q <= rd_val;
    end
  end

endmodule

// File: doc/cop0_intc.md
Name: cop0_intc

Overview:
Interrupt/timer front end that produces the external cause vector consumed by cop0.
- Samples hardware interrupt lines and latches per-line pending state (edge- or level-mode).
- Applies an enable mask and runs a Count/Compare timer.
- Drives cause bits [15:8] so cop0 can raise exceptions against status[15:8].
- Software reads and clears it through a small mfc0/mtc0-style register port with the same 1-cycle-stall read handshake the pipeline already uses for cop0.

Parameters:
NUMIRQ, 6, number of hardware interrupt lines (1..7); line i drives cause bit 8+i.
CNTW, 32, Count/Compare width (1..32); zero-extended to 32 bits on read.

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
irq_in  input  NUMIRQ  raw interrupt lines, already synchronous to clk
addr  input  3  register select
wdata  input  32  write data
we  input  1  register write strobe
re  input  1  register read request
rdata  output  32  registered read data
stalled  output  1  read stall to pipeline
ext_cause  output  32  cause vector to cop0 ext_cause_in

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on resetn. All state is cleared when resetn=0 at a posedge, including mid-read.
- Reset values: rdata=0, stalled follows re (no stall memory), ext_cause=0, PENDING=0, EDGE=0, ENABLE=0, COUNT=0, COMPARE=0, TPEND=0, irq_prev=0.
- Register map:
  - 0 PENDING: bits [NUMIRQ-1:0]; read; write-1-to-clear.
  - 1 EDGE: 1=rising-edge mode, 0=level mode.
  - 2 ENABLE.
  - 3 COUNT.
  - 4 COMPARE.
  - 5 TPEND: bit0; read-only.
  - 6–7: read 0, writes ignored.
- Per-line pending update, line i, every cycle:
  - Level mode: PENDING[i] <= irq_in[i]; W1C has no lasting effect.
  - Edge mode: set on irq_in[i]=1 && irq_prev[i]=0; cleared by W1C. Set and W1C in the same cycle: set wins.
  - irq_prev <= irq_in every cycle.
- Timer:
  - COUNT increments by 1 every cycle (mod 2^CNTW) unless written; a write loads wdata[CNTW-1:0].
  - Match is COUNT==COMPARE, using current register values, with COMPARE != 0. A match sets TPEND.
  - A write to COMPARE loads it and clears TPEND. Clear wins over a same-cycle match.
- ext_cause, registered, 1-cycle latency from any state change:
  - Bit 8+i = PENDING[i] & ENABLE[i].
  - Bit 15 = TPEND.
  - All other bits are 0.
  - If NUMIRQ=7, line 6 and TPEND are ORed into bit 15.
- Read handshake:
  - Internal T flop captures stalled each cycle; stalled = T ? 0 : re.
  - A read stalls exactly one cycle. rdata is registered on that cycle and holds until the next read.
  - Read and write in the same cycle return the pre-write value.
- Reset mid-stall clears T; the stall drops on the next cycle unless re is still high.

Optional Feature:
INTC_TIMER_EN.
- Defined: COUNT/COMPARE/TPEND are implemented as above.
- Undefined: the timer logic is removed; addresses 3/4/5 read 0 and ignore writes; ext_cause bit 15 carries only line 6 when NUMIRQ=7, else 0.

Decomposition:
- Package cop0_intc_pkg holds:
  - Register address constants (INTC_PENDING..INTC_TPEND).
  - Cause bit base constant (8) and timer cause bit (15).
- One natural sub-module, cop0_intc_timer: COUNT/COMPARE/TPEND with write ports and match output. It is instantiated only under INTC_TIMER_EN.

Test Plan:
- Reset, then ENABLE=0x3F, EDGE=0, irq_in=0x04 -> PENDING=0x04; ext_cause=0x0000_0400 one cycle after PENDING updates; irq_in=0 -> ext_cause returns to 0.
- EDGE=0x01, ENABLE=0x01, pulse irq_in[0] for 1 cycle -> PENDING=0x01 sticky, ext_cause bit8=1; write PENDING=0x01 -> cleared; W1C on the same cycle as a new rising edge -> stays 1.
- re=1 at addr 2 after ENABLE=0x15 -> stalled=1 for exactly one cycle, rdata=0x15 on the following cycle; same-cycle we to addr 2 with 0x3F -> rdata still 0x15.
- COUNT=0x10, COMPARE=0x14 -> TPEND=1 four cycles after the writes, ext_cause bit15=1 one cycle later; write COMPARE=0x20 -> TPEND=0 and bit15 clears.
- COMPARE=0 with COUNT wrapping from 0xFFFF_FFFF to 0 -> TPEND never sets.
- Assert resetn=0 during a pending read stall with PENDING=0x3F -> all registers 0, stalled=0 next cycle with re=0, ext_cause=0.
